// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes a 26-bit instruction field plus class code into a DATA_W immediate, with a MOVZ/MOVK/MOVN accumulator.
// Latency: one cycle from acceptance to a valid buffer head; throughput one per cycle with out_ready held high.
// Backpressure: 2-entry elastic output buffer; in_ready depends only on the registered count. Optional macro IMM_GEN_BRANCH_SHIFT_EN turns B/CB results into byte offsets.
module imm_gen_pipe #(
    parameter int DATA_W    = 64,
    parameter int BUF_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [25:0]       in_instr,
    input  logic [2:0]        in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [DATA_W-1:0] acc_q
);

    typedef enum logic [2:0] {
        CLS_I    = 3'b000,
        CLS_D    = 3'b001,
        CLS_B    = 3'b010,
        CLS_CB   = 3'b011,
        CLS_MOVZ = 3'b100,
        CLS_MOVK = 3'b101,
        CLS_MOVN = 3'b110,
        CLS_ILL  = 3'b111
    } imm_class_t;

    // Only the 32/64-bit datapaths and a two-entry skid buffer are meaningful.
    if ((DATA_W != 32 && DATA_W != 64) || BUF_DEPTH != 2) begin : g_bad_param
        $error("imm_gen_pipe: DATA_W must be 32 or 64 and BUF_DEPTH must be 2");
    end

    imm_class_t        cls;
    logic [15:0]       imm16;
    logic [1:0]        hw;
    logic [5:0]        sh;
    logic [63:0]       acc_ext;
    logic [63:0]       res64;
    logic              gen_err;
    logic              is_mov;
    logic              hw_bad;
    logic              acc_wr;
    logic [DATA_W-1:0] gen_data;

    logic              push;
    logic              pop;
    logic [1:0]        count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [DATA_W-1:0] buf_data [2];
    logic              buf_err  [2];

    assign cls   = imm_class_t'(in_ctrl);
    assign imm16 = in_instr[20:5];
    assign hw    = in_instr[22:21];
    assign sh    = {hw, 4'b0000};

    // A 32-bit datapath has no halfwords 2 and 3 to move into.
    assign hw_bad = (DATA_W == 32) && hw[1];

    // Zero-extend the accumulator so MOVK can be computed on a common 64-bit path.
    always_comb begin
        acc_ext = '0;
        acc_ext[DATA_W-1:0] = acc_q;
    end

    // Decode the immediate class into a 64-bit result and error flag.
    always_comb begin
        res64   = '0;
        gen_err = 1'b0;
        is_mov  = 1'b0;
        case (cls)
            CLS_I:    res64 = {{52{in_instr[21]}}, in_instr[21:10]};
            CLS_D:    res64 = {{55{in_instr[20]}}, in_instr[20:12]};
            CLS_B:    res64 = {{38{in_instr[25]}}, in_instr[25:0]};
            CLS_CB:   res64 = {{45{in_instr[23]}}, in_instr[23:5]};
            CLS_MOVZ: begin
                is_mov = 1'b1;
                res64  = {48'b0, imm16} << sh;
            end
            CLS_MOVK: begin
                is_mov = 1'b1;
                res64  = (acc_ext & ~({48'b0, 16'hFFFF} << sh)) | ({48'b0, imm16} << sh);
            end
            CLS_MOVN: begin
                is_mov = 1'b1;
                res64  = ~({48'b0, imm16} << sh);
            end
            default: begin
                res64   = '0;
                gen_err = 1'b1;
            end
        endcase
`ifdef IMM_GEN_BRANCH_SHIFT_EN
        // Branch offsets become byte offsets when this build option is on.
        if (cls == CLS_B || cls == CLS_CB) begin
            res64 = res64 << 2;
        end
`endif
        if (is_mov && hw_bad) begin
            res64   = '0;
            gen_err = 1'b1;
        end
    end

    assign gen_data = res64[DATA_W-1:0];
    assign acc_wr   = push && is_mov && !gen_err;

    // Handshake: in_ready comes only from the registered count, never from out_ready.
    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = buf_data[rd_ptr];
    assign out_err   = buf_err[rd_ptr];

    // Elastic output buffer: write/read pointers and occupancy count.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_err[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= gen_data;
                buf_err[wr_ptr]  <= gen_err;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Wide-immediate accumulator follows every accepted, legal move-wide result.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            acc_q <= '0;
        end else if (acc_wr) begin
            acc_q <= gen_data;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic        CLK;
    logic        resetl;
    logic        in_valid;
    logic [25:0] in_instr;
    logic [2:0]  in_ctrl;
    logic        out_ready;

    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_data64, acc_q64;
    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_data32, acc_q32;

    int passed = 0;
    int total  = 0;

    // Reference state: expected buffer contents {err, data} and accumulators.
    logic [64:0] q64[$];
    logic [64:0] q32[$];
    logic [63:0] acc64;
    logic [63:0] acc32;

    imm_gen_pipe #(.DATA_W(64), .BUF_DEPTH(2)) u_dut64 (
        .CLK(CLK), .resetl(resetl),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_ctrl(in_ctrl),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_data(out_data64), .out_err(out_err64), .acc_q(acc_q64)
    );

    imm_gen_pipe #(.DATA_W(32), .BUF_DEPTH(2)) u_dut32 (
        .CLK(CLK), .resetl(resetl),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_ctrl(in_ctrl),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_data(out_data32), .out_err(out_err32), .acc_q(acc_q32)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Architectural meaning of each class, computed as signed/unsigned arithmetic.
    function automatic logic [64:0] ref_imm(input int w, input logic [2:0] c,
                                            input logic [25:0] ins, input logic [63:0] acc);
        longint      v;
        logic [63:0] r, imm, field, scale, mask;
        logic        e;
        int          sh;
        v = 0; r = '0; e = 1'b0;
        sh    = 16 * int'(ins[22:21]);
        imm   = 64'(ins[20:5]);
        scale = 64'd1 << sh;
        mask  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        case (c)
            3'd0: begin v = longint'(ins[21:10]); if (ins[21]) v -= 4096;     r = v; end
            3'd1: begin v = longint'(ins[20:12]); if (ins[20]) v -= 512;      r = v; end
            3'd2: begin
                v = longint'(ins); if (ins[25]) v -= 67108864;
`ifdef IMM_GEN_BRANCH_SHIFT_EN
                v = v * 4;
`endif
                r = v;
            end
            3'd3: begin
                v = longint'(ins[23:5]); if (ins[23]) v -= 524288;
`ifdef IMM_GEN_BRANCH_SHIFT_EN
                v = v * 4;
`endif
                r = v;
            end
            3'd4, 3'd5, 3'd6: begin
                if (w == 32 && sh >= 32) begin
                    e = 1'b1;
                end else if (c == 3'd4) begin
                    r = imm * scale;
                end else if (c == 3'd5) begin
                    field = (acc / scale) % 64'd65536;
                    r = acc - field * scale + imm * scale;
                end else begin
                    r = ~(imm * scale);
                end
            end
            default: e = 1'b1;
        endcase
        return {e, r & mask};
    endfunction

    // Apply one clock edge to the reference: pop the head, then append the accepted entry.
    task automatic model_edge();
        logic [64:0] r64, r32;
        logic        acc_ok64, acc_ok32;
        logic        psh64, psh32, pp64, pp32;
        psh64 = in_valid && (q64.size() < 2);
        psh32 = in_valid && (q32.size() < 2);
        pp64  = out_ready && (q64.size() > 0);
        pp32  = out_ready && (q32.size() > 0);
        r64 = ref_imm(64, in_ctrl, in_instr, acc64);
        r32 = ref_imm(32, in_ctrl, in_instr, acc32);
        acc_ok64 = (in_ctrl inside {3'd4, 3'd5, 3'd6}) && !r64[64];
        acc_ok32 = (in_ctrl inside {3'd4, 3'd5, 3'd6}) && !r32[64];
        if (pp64) void'(q64.pop_front());
        if (pp32) void'(q32.pop_front());
        if (psh64) begin
            q64.push_back(r64);
            if (acc_ok64) acc64 = r64[63:0];
        end
        if (psh32) begin
            q32.push_back(r32);
            if (acc_ok32) acc32 = r32[63:0];
        end
    endtask

    task automatic check_outputs();
        chk1("out_valid64", out_valid64, q64.size() != 0);
        if (q64.size() != 0) begin
            chk("out_data64", out_data64, q64[0][63:0]);
            chk1("out_err64", out_err64, q64[0][64]);
        end
        chk("acc_q64", acc_q64, acc64);
        chk1("out_valid32", out_valid32, q32.size() != 0);
        if (q32.size() != 0) begin
            chk("out_data32", {32'b0, out_data32}, q32[0][63:0]);
            chk1("out_err32", out_err32, q32[0][64]);
        end
        chk("acc_q32", {32'b0, acc_q32}, acc32);
    endtask

    // One cycle: drive at the falling edge, update the model at the rising edge, check at the next falling edge.
    task automatic step(input logic v, input logic [25:0] ins, input logic [2:0] c, input logic r);
        in_valid  = v;
        in_instr  = ins;
        in_ctrl   = c;
        out_ready = r;
        chk1("in_ready64", in_ready64, q64.size() < 2);
        chk1("in_ready32", in_ready32, q32.size() < 2);
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_outputs();
    endtask

    function automatic logic [25:0] mov_instr(input logic [1:0] hw, input logic [15:0] imm);
        return {3'b0, hw, imm, 5'b0};
    endfunction

    initial begin
        resetl = 1'b0; in_valid = 1'b0; in_instr = '0; in_ctrl = '0; out_ready = 1'b0;
        acc64 = '0; acc32 = '0;
        repeat (2) @(negedge CLK);
        chk1("rst_out_valid", out_valid64, 1'b0);
        chk("rst_out_data", out_data64, 64'd0);
        chk1("rst_out_err", out_err64, 1'b0);
        chk("rst_acc", acc_q64, 64'd0);
        chk1("rst_in_ready", in_ready64, 1'b1);
        resetl = 1'b1;
        @(negedge CLK);

        // I class with the sign bit of the 12-bit field set.
        step(1'b1, 26'h0200000, 3'd0, 1'b1);
        chk("i_class_neg", out_data64, 64'hFFFF_FFFF_FFFF_F800);
        chk1("i_class_err", out_err64, 1'b0);
        step(1'b0, '0, 3'd0, 1'b1);

        // MOVZ then MOVK back-to-back build a constant.
        step(1'b1, mov_instr(2'd1, 16'h1234), 3'd4, 1'b1);
        chk("movz_out", out_data64, 64'h0000_0000_1234_0000);
        step(1'b1, mov_instr(2'd0, 16'hABCD), 3'd5, 1'b1);
        chk("movk_out", out_data64, 64'h0000_0000_1234_ABCD);
        chk("movk_acc", acc_q64, 64'h0000_0000_1234_ABCD);
        step(1'b0, '0, 3'd0, 1'b1);

        // Backpressure: two accepted, third held until space frees.
        step(1'b1, 26'h0001400, 3'd0, 1'b0);
        step(1'b1, 26'h0002000, 3'd1, 1'b0);
        chk1("full_in_ready", in_ready64, 1'b0);
        step(1'b1, 26'h0000100, 3'd3, 1'b0);
        chk("full_head_hold", out_data64, 64'h0000_0000_0000_0005);
        step(1'b1, 26'h0000100, 3'd3, 1'b1);
        step(1'b1, 26'h0000100, 3'd3, 1'b1);
        step(1'b0, '0, 3'd0, 1'b1);
        step(1'b0, '0, 3'd0, 1'b1);

        // B class all ones.
        step(1'b1, 26'h3FF_FFFF, 3'd2, 1'b1);
`ifdef IMM_GEN_BRANCH_SHIFT_EN
        chk("b_all_ones", out_data64, 64'hFFFF_FFFF_FFFF_FFFC);
`else
        chk("b_all_ones", out_data64, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        step(1'b0, '0, 3'd0, 1'b1);

        // Upper halfword on the 32-bit datapath is illegal and leaves acc alone.
        step(1'b1, mov_instr(2'd2, 16'h5555), 3'd4, 1'b1);
        chk("w32_hw2_data", {32'b0, out_data32}, 64'd0);
        chk1("w32_hw2_err", out_err32, 1'b1);
        chk("w32_hw2_acc", {32'b0, acc_q32}, 64'h1234_ABCD);
        chk("w64_hw2_data", out_data64, 64'h0000_5555_0000_0000);
        step(1'b1, 26'h155_5555, 3'd7, 1'b1);
        chk1("ill_err", out_err64, 1'b1);
        chk("ill_data", out_data64, 64'd0);
        step(1'b0, '0, 3'd0, 1'b1);

        // Reset mid-stream with two entries buffered.
        step(1'b1, mov_instr(2'd0, 16'h1234), 3'd4, 1'b0);
        step(1'b1, 26'h0000400, 3'd0, 1'b0);
        chk("pre_rst_acc", acc_q64, 64'h1234);
        #2 resetl = 1'b0;
        #1;
        q64.delete(); q32.delete(); acc64 = '0; acc32 = '0;
        chk1("mid_rst_valid", out_valid64, 1'b0);
        chk("mid_rst_acc", acc_q64, 64'd0);
        chk1("mid_rst_ready", in_ready64, 1'b1);
        in_valid = 1'b0;
        @(negedge CLK);
        resetl = 1'b1;
        #1;
        chk1("post_rst_ready", in_ready64, 1'b1);
        chk1("post_rst_valid32", out_valid32, 1'b0);

        // Randomised traffic against the reference.
        for (int n = 0; n < 300; n++) begin
            logic [2:0] c;
            c = 3'($urandom_range(0, 7));
            step(1'($urandom_range(0, 3) != 0), 26'($urandom), c, 1'($urandom_range(0, 2) != 0));
        end
        for (int n = 0; n < 3; n++) step(1'b0, '0, 3'd0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the ARMv8 datapath. Successor to the combinational sign extender.
- Accepts a 26-bit instruction field plus an immediate-class code over a valid/ready handshake.
- Produces a DATA_W-bit immediate through a 2-entry elastic output buffer.
- Adds a wide-immediate accumulator so MOVZ/MOVK/MOVN sequences build full constants; flags illegal encodings.

Parameters:
DATA_W, 64, output width; legal values 32 or 64
BUF_DEPTH, 2, output buffer entries; fixed at 2 (skid buffer), parameter for documentation/assertion only

Ports:
CLK  input  1  clock, rising edge
resetl  input  1  asynchronous active-low reset
in_valid  input  1  instruction field valid
in_ready  output  1  block can accept this cycle
in_instr  input  26  instruction bits [25:0]
in_ctrl  input  3  immediate class
out_valid  output  1  out_data/out_err valid
out_ready  input  1  consumer accepts this cycle
out_data  output  DATA_W  generated immediate
out_err  output  1  illegal encoding for this entry
acc_q  output  DATA_W  current wide-immediate accumulator (debug/forwarding)

Behaviour:
- Classes (in_ctrl):
  - 000 I: sext(instr[21:10]) from bit 21.
  - 001 D: sext(instr[20:12]) from bit 20.
  - 010 B: sext(instr[25:0]) from bit 25.
  - 011 CB: sext(instr[23:5]) from bit 23.
  - 100 MOVZ: imm16=instr[20:5], hw=instr[22:21]; result = imm16 << (16*hw).
  - 101 MOVK: result = acc with bits [16*hw+15:16*hw] replaced by imm16.
  - 110 MOVN: result = ~(imm16 << 16*hw), truncated to DATA_W.
  - 111: result 0, err=1.
- Sign extension always fills to DATA_W. Upper bits are truncated when DATA_W=32; B keeps bits [31:0].
- DATA_W=32 and hw>=2 on MOVZ/MOVK/MOVN: result 0, err=1, accumulator unchanged.
- Accumulator:
  - Updated only on an accepted, non-error MOVZ/MOVK/MOVN; acc <= result.
  - Other classes leave it unchanged.
  - Visible on acc_q the cycle after acceptance.
  - Back-to-back MOVK uses the updated acc (no bubble).
- Handshake:
  - Transfer on in_valid & in_ready, and on out_valid & out_ready. in_valid may be held.
  - in_ready = (count < 2); derived from registered count only, no combinational path from out_ready.
  - Buffer FIFO-ordered; count 0..2. Push and pop in the same cycle leave count unchanged.
  - When full, in_ready=0 and pushes are ignored even if out_ready=1 that cycle.
- Latency: accepted at edge N -> out_valid high and head data valid after edge N when buffer was empty. Throughput 1/cycle with out_ready held high.
- out_data/out_err always reflect the buffer head. Both are held stable while out_valid & !out_ready.
- Reset (async assert, sync-safe deassert handled upstream):
  - count=0, out_valid=0, out_data=0, out_err=0, acc_q=0, in_ready=1 after release.
  - Reset mid-stream discards all buffered entries.

Optional Feature:
- Macro IMM_GEN_BRANCH_SHIFT_EN.
- Defined: B and CB results are shifted left by 2 after sign extension (byte offset); all other classes unaffected.
- Undefined: B and CB results are word offsets as specified above.

Test Plan:
- I class, instr[21:10]=0x800, DATA_W=64, out_ready=1 -> out_data=0xFFFF_FFFF_FFFF_F800 one cycle after accept, out_err=0.
- MOVZ hw=1 imm16=0x1234, then MOVK hw=0 imm16=0xABCD back-to-back -> outputs 0x0000_0000_1234_0000 then 0x0000_0000_1234_ABCD; acc_q=0x1234_ABCD.
- out_ready=0, three consecutive valid inputs -> first two accepted, in_ready=0 from the cycle after the second; third held. Raise out_ready -> drain in order, third accepted next cycle.
- B class, instr=0x3FF_FFFF -> 0xFFFF_FFFF_FFFF_FFFF without the macro; 0xFFFF_FFFF_FFFF_FFFC with IMM_GEN_BRANCH_SHIFT_EN.
- DATA_W=32, MOVZ hw=2 imm16=0x5555 -> out_data=0, out_err=1, acc_q unchanged. in_ctrl=111 -> out_err=1.
- Two entries buffered, acc_q=0x1234, assert resetl=0 mid-cycle -> out_valid=0, acc_q=0, count=0 immediately; after release in_ready=1.
